toy_panel_ctrl: RTL and testbench
=================================

Name: toy_panel_ctrl

Overview:
- Front-panel controller for the TOY machine; sole master on the main memory read/write port while the CPU is halted.
- Turns operator switch settings and SET/LOAD/LOOK button presses into single memory write or read transactions.
- Keeps the panel address register and drives the address/data LED latches.
- Sits directly upstream of main memory and shares its 8-bit address / 16-bit word format.

Parameters:
- ADDR_W, 8, memory address width (256 words).
- DATA_W, 16, memory word width.
- AUTO_INC, 1, when 1 the address register increments (mod 2^ADDR_W) after each completed LOAD or LOOK.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  reset, synchronous, active-high.
- halted_i  input  1  CPU halted; panel operations are accepted only while 1.
- sw_addr_i  input  ADDR_W  address switches.
- sw_data_i  input  DATA_W  data switches.
- btn_set_i  input  1  SET ADDR button, level, already debounced and synchronous.
- btn_load_i  input  1  LOAD button, level, debounced and synchronous.
- btn_look_i  input  1  LOOK button, level, debounced and synchronous.
- mem  mem_rwport.master  -  memory port: val, wen, addr[7:0], wdata[15:0] out; rdata[15:0], rdy in.
- led_addr_o  output  ADDR_W  current panel address register.
- led_data_o  output  DATA_W  last written or read word.
- busy_o  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_ni=1 at a clock edge):
  - state=IDLE, addr_q=0, led_data_o=0, mem.val=0, mem.wen=0, busy_o=0.
  - Button edge-detect history is cleared to the current button levels, so a button held through reset does not fire.
  - Reset during REQ or RDATA aborts the transaction. mem.val is 0 from the first cycle after the reset edge. No address increment, no LED update.
- Button press events:
  - An event is a rising edge: level 1 now, 0 in the previous cycle.
  - An event is accepted only if state=IDLE and halted_i=1. Otherwise it is discarded, never queued.
  - Simultaneous events: priority SET > LOAD > LOOK. Lower-priority events in that cycle are discarded.
- States: IDLE, REQ, RDATA.
  - IDLE, SET event: addr_q <= sw_addr_i. State stays IDLE. No memory access. Single cycle, so busy_o stays 0.
  - IDLE, LOAD event: capture wdata_q <= sw_data_i, set op=write, go to REQ.
  - IDLE, LOOK event: set op=read, go to REQ.
  - REQ, memory drive: mem.val=1, mem.addr=addr_q, mem.wen=(op==write), mem.wdata=wdata_q. All held stable until acceptance (val && rdy at a clock edge).
  - REQ, write accepted: led_data_o <= wdata_q, addr_q increments if AUTO_INC, go to IDLE.
  - REQ, read accepted: go to RDATA.
  - RDATA: mem.val=0. Sample mem.rdata into led_data_o (read data is valid exactly one cycle after acceptance). Increment addr_q if AUTO_INC. Go to IDLE.
- Timing:
  - Write takes 2 cycles from the event cycle to IDLE when rdy=1.
  - Read takes 3 cycles, and led_data_o updates at the end of the RDATA cycle.
- Addresses: increment wraps 0xFF -> 0x00. sw_data_i changing while in REQ has no effect, because the word was captured at the event.
- Signals outside REQ: mem.val=0 and mem.wen=0 in every state other than REQ. mem.addr and mem.wdata are don't-care when val=0, but are driven from addr_q/wdata_q (no X).
- halted_i dropping during REQ/RDATA: the transaction still completes; the CPU is responsible for not contending.
- busy_o=1 exactly in REQ and RDATA.

Test Plan:
- Reset, then SET with sw_addr=0x10, LOAD sw_data=0xBEEF, rdy=1 -> one cycle val=1,wen=1,addr=0x10,wdata=0xBEEF; led_data=0xBEEF; led_addr=0x11; busy high 1 cycle.
- SET 0x10, LOOK with the memory model returning 0xBEEF one cycle after acceptance -> val=1,wen=0,addr=0x10 for 1 cycle; led_data=0xBEEF after the RDATA cycle; led_addr=0x11.
- Hold rdy=0 for 5 cycles during LOAD -> val/addr/wdata stable all 5 cycles; toggling sw_data in that window does not change wdata; completion on the first rdy=1 edge.
- SET 0xFF, LOAD -> led_addr wraps to 0x00. With AUTO_INC=0 -> led_addr stays 0xFF.
- Edge cases:
  - LOAD and LOOK rising in the same cycle -> only the write occurs.
  - LOOK pressed while busy -> ignored.
  - Any button with halted_i=0 -> no val pulse.
  - Button held high through reset -> no event.
- Assert reset while in REQ with rdy=0 -> next cycle val=0, led_addr=0, led_data=0, busy=0; a subsequent LOOK works normally.

Source files
------------

// File: rtl/toy_panel_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_rwport : single-transaction memory read/write port (val/rdy handshake)
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_rwport #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              val;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rdy;

   modport master (output val, wen, addr, wdata, input rdata, rdy);
   modport slave  (input val, wen, addr, wdata, output rdata, rdy);
endinterface
`default_nettype wire

// File: rtl/toy_panel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// toy_panel_ctrl : TOY front panel, turns SET/LOAD/LOOK presses into memory ops
// Rev 1.0
// ---------------------------------------------------------------------------
module toy_panel_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int AUTO_INC = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              halted_i,
   input  logic [ADDR_W-1:0] sw_addr_i,
   input  logic [DATA_W-1:0] sw_data_i,
   input  logic              btn_set_i,
   input  logic              btn_load_i,
   input  logic              btn_look_i,
   mem_rwport.master         mem,
   output logic [ADDR_W-1:0] led_addr_o,
   output logic [DATA_W-1:0] led_data_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RDATA = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_addr_one = 1;

   state_t            r_state;
   logic [2:0]        r_btn_prev;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_led;
   logic              r_val;
   logic              r_wen;
   logic              r_op_wr;
   logic              r_busy;

   logic [2:0]        w_btn;
   logic [2:0]        w_rise;
   logic              w_accept;

   assign w_btn    = {btn_set_i, btn_load_i, btn_look_i};
   assign w_rise   = w_btn & ~r_btn_prev;
   assign w_accept = (r_state == ST_IDLE) && halted_i;

   // History follows the buttons in reset too, so a held button never fires.
   always_ff @(posedge clk_i) begin
      r_btn_prev <= w_btn;
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_led   <= '0;
         r_val   <= 1'b0;
         r_wen   <= 1'b0;
         r_op_wr <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_rise[2]) begin
                     r_addr <= sw_addr_i;
                  end else if (w_rise[1]) begin
                     r_wdata <= sw_data_i;
                     r_op_wr <= 1'b1;
                     r_val   <= 1'b1;
                     r_wen   <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= ST_REQ;
                  end else if (w_rise[0]) begin
                     r_op_wr <= 1'b0;
                     r_val   <= 1'b1;
                     r_wen   <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem.rdy) begin
                  r_val <= 1'b0;
                  r_wen <= 1'b0;
                  if (r_op_wr) begin
                     r_led   <= r_wdata;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                     if (AUTO_INC != 0) r_addr <= r_addr + c_addr_one;
                  end else begin
                     r_state <= ST_RDATA;
                  end
               end
            end
            ST_RDATA: begin
               r_led   <= mem.rdata;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
               if (AUTO_INC != 0) r_addr <= r_addr + c_addr_one;
            end
            default: begin
               r_val   <= 1'b0;
               r_wen   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem.val    = r_val;
   assign mem.wen    = r_wen;
   assign mem.addr   = r_addr;
   assign mem.wdata  = r_wdata;
   assign led_addr_o = r_addr;
   assign led_data_o = r_led;
   assign busy_o     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_toy_panel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_toy_panel_ctrl : directed and randomized checks of the TOY panel controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_toy_panel_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halted = 1'b1;
   logic [7:0]  sw_addr = '0;
   logic [15:0] sw_data = '0;
   logic        btn_set = 1'b0;
   logic        btn_load = 1'b0;
   logic        btn_look = 1'b0;
   logic [7:0]  led_addr, led_addr0;
   logic [15:0] led_data, led_data0;
   logic        busy, busy0;

   mem_rwport #(.ADDR_W(8), .DATA_W(16)) mem_if ();
   mem_rwport #(.ADDR_W(8), .DATA_W(16)) mem_if0 ();

   toy_panel_ctrl #(.ADDR_W(8), .DATA_W(16), .AUTO_INC(1)) dut (
      .clk_i(clk), .rst_ni(rst), .halted_i(halted),
      .sw_addr_i(sw_addr), .sw_data_i(sw_data),
      .btn_set_i(btn_set), .btn_load_i(btn_load), .btn_look_i(btn_look),
      .mem(mem_if), .led_addr_o(led_addr), .led_data_o(led_data), .busy_o(busy)
   );

   toy_panel_ctrl #(.ADDR_W(8), .DATA_W(16), .AUTO_INC(0)) dut0 (
      .clk_i(clk), .rst_ni(rst), .halted_i(halted),
      .sw_addr_i(sw_addr), .sw_data_i(sw_data),
      .btn_set_i(btn_set), .btn_load_i(btn_load), .btn_look_i(btn_look),
      .mem(mem_if0), .led_addr_o(led_addr0), .led_data_o(led_data0), .busy_o(busy0)
   );

   assign mem_if0.rdy   = 1'b1;
   assign mem_if0.rdata = 16'h0000;

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int txn_cnt = 0;

   // Reference model state: what the panel should show, and what memory holds
   logic [7:0]  ref_addr;
   logic [15:0] ref_led;
   logic [15:0] ref_mem [256];

   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 40503 + 12345);
   endfunction

   // Memory: accepts on val&&rdy, returns read data one cycle after acceptance
   logic [15:0] mem_arr [256];
   bit          mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else if (mem_if.val && mem_if.rdy) begin
         txn_cnt <= txn_cnt + 1;
         if (mem_if.wen) mem_arr[mem_if.addr] <= mem_if.wdata;
         else            mem_if.rdata <= mem_arr[mem_if.addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] which);
      {btn_set, btn_load, btn_look} = which;
      tick();
      {btn_set, btn_load, btn_look} = 3'b000;
   endtask

   task automatic do_set(input logic [7:0] a);
      sw_addr = a;
      press(3'b100);
      tick();
   endtask

   task automatic wait_idle(input int max, input bit rnd);
      int n = 0;
      while (busy && n < max) begin
         if (rnd) begin
            mem_if.rdy = ($urandom_range(0, 3) != 0);
            sw_data    = 16'($urandom);
         end
         tick();
         n++;
      end
      mem_if.rdy = 1'b1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_load = 1'b1; mem_if.rdy = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({mem_if.val, mem_if.wen, busy, led_addr, led_data} !== 27'd0) begin
         n_bad++;
         $display("FAIL reset_state: val/wen/busy/addr/data=%b%b%b %h %h want 000 00 0000",
                  mem_if.val, mem_if.wen, busy, led_addr, led_data);
      end
      rst = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if ({busy, mem_if.val} !== 2'b00 || txn_cnt !== 0) begin
         n_bad++;
         $display("FAIL held_btn: busy=%b val=%b txns=%0d want 0 0 0", busy, mem_if.val, txn_cnt);
      end
      btn_load = 1'b0;
      tick();
      ref_addr = 8'h00;
      ref_led  = 16'h0000;
   endtask

   task automatic test_write();
      sw_addr = 8'h10;
      press(3'b100);
      n_cmp++;
      if ({busy, led_addr} !== {1'b0, 8'h10}) begin
         n_bad++;
         $display("FAIL set_addr: busy=%b addr=%h want 0 10", busy, led_addr);
      end
      tick();
      sw_data = 16'hBEEF;
      press(3'b010);
      n_cmp++;
      if ({mem_if.val, mem_if.wen, busy, mem_if.addr, mem_if.wdata} !== {3'b111, 8'h10, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL write_req: val/wen/busy=%b%b%b addr=%h wdata=%h want 111 10 beef",
                  mem_if.val, mem_if.wen, busy, mem_if.addr, mem_if.wdata);
      end
      tick();
      n_cmp++;
      if ({mem_if.val, busy, led_addr, led_data} !== {2'b00, 8'h11, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL write_done: val/busy=%b%b addr=%h data=%h want 00 11 beef",
                  mem_if.val, busy, led_addr, led_data);
      end
      ref_mem[8'h10] = 16'hBEEF;
   endtask

   task automatic test_read();
      do_set(8'h30);
      sw_data = 16'h5555;
      press(3'b010);
      wait_idle(10, 1'b0);
      ref_mem[8'h30] = 16'h5555;
      do_set(8'h10);
      press(3'b001);
      n_cmp++;
      if ({mem_if.val, mem_if.wen, busy, mem_if.addr} !== {3'b101, 8'h10}) begin
         n_bad++;
         $display("FAIL read_req: val/wen/busy=%b%b%b addr=%h want 101 10",
                  mem_if.val, mem_if.wen, busy, mem_if.addr);
      end
      tick();
      n_cmp++;
      if ({mem_if.val, busy, led_data} !== {2'b01, 16'h5555}) begin
         n_bad++;
         $display("FAIL read_rdata: val/busy=%b%b data=%h want 01 5555", mem_if.val, busy, led_data);
      end
      tick();
      n_cmp++;
      if ({busy, led_addr, led_data} !== {1'b0, 8'h11, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL read_done: busy=%b addr=%h data=%h want 0 11 beef", busy, led_addr, led_data);
      end
   endtask

   task automatic test_stall();
      do_set(8'h40);
      mem_if.rdy = 1'b0;
      sw_data = 16'hA5A5;
      press(3'b010);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({mem_if.val, mem_if.wen, mem_if.addr, mem_if.wdata} !== {2'b11, 8'h40, 16'hA5A5}) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: val/wen=%b%b addr=%h wdata=%h want 11 40 a5a5",
                     i, mem_if.val, mem_if.wen, mem_if.addr, mem_if.wdata);
         end
         sw_data = 16'($urandom);
         tick();
      end
      mem_if.rdy = 1'b1;
      tick();
      n_cmp++;
      if ({busy, led_addr, led_data} !== {1'b0, 8'h41, 16'hA5A5}) begin
         n_bad++;
         $display("FAIL stall_done: busy=%b addr=%h data=%h want 0 41 a5a5", busy, led_addr, led_data);
      end
      ref_mem[8'h40] = 16'hA5A5;
   endtask

   task automatic test_wrap();
      logic [15:0] d;
      d = 16'($urandom);
      do_set(8'hFF);
      sw_data = d;
      press(3'b010);
      wait_idle(10, 1'b0);
      ref_mem[8'hFF] = d;
      n_cmp++;
      if ({led_addr, led_data} !== {8'h00, d}) begin
         n_bad++;
         $display("FAIL wrap_inc: addr=%h data=%h want 00 %h", led_addr, led_data, d);
      end
      n_cmp++;
      if ({led_addr0, led_data0} !== {8'hFF, d}) begin
         n_bad++;
         $display("FAIL wrap_noinc: addr=%h data=%h want ff %h", led_addr0, led_data0, d);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] d;
      int          c;
      d = 16'($urandom);
      do_set(8'h50);
      c = txn_cnt;
      sw_data = d;
      press(3'b011);
      n_cmp++;
      if ({mem_if.val, mem_if.wen} !== 2'b11) begin
         n_bad++;
         $display("FAIL simul_req: val/wen=%b%b want 11", mem_if.val, mem_if.wen);
      end
      wait_idle(10, 1'b0);
      tick(); tick();
      ref_mem[8'h50] = d;
      n_cmp++;
      if ({busy, led_addr, led_data} !== {1'b0, 8'h51, d} || txn_cnt !== c + 1) begin
         n_bad++;
         $display("FAIL simul_done: busy=%b addr=%h data=%h txns=%0d want 0 51 %h %0d",
                  busy, led_addr, led_data, txn_cnt - c, d, 1);
      end
   endtask

   task automatic test_busy_look();
      logic [15:0] d;
      int          c;
      d = 16'($urandom);
      do_set(8'h60);
      c = txn_cnt;
      mem_if.rdy = 1'b0;
      sw_data = d;
      press(3'b010);
      tick();
      press(3'b001);
      tick();
      mem_if.rdy = 1'b1;
      tick(); tick(); tick(); tick();
      ref_mem[8'h60] = d;
      n_cmp++;
      if ({busy, led_addr, led_data} !== {1'b0, 8'h61, d} || txn_cnt !== c + 1) begin
         n_bad++;
         $display("FAIL busy_look: busy=%b addr=%h data=%h txns=%0d want 0 61 %h 1",
                  busy, led_addr, led_data, txn_cnt - c, d);
      end
      ref_addr = 8'h61;
      ref_led  = d;
   endtask

   task automatic test_not_halted();
      int c;
      c = txn_cnt;
      halted = 1'b0;
      sw_addr = 8'hAA;
      press(3'b100); tick();
      press(3'b010); tick();
      press(3'b001); tick(); tick();
      n_cmp++;
      if ({busy, mem_if.val, led_addr, led_data} !== {2'b00, ref_addr, ref_led} || txn_cnt !== c) begin
         n_bad++;
         $display("FAIL not_halted: busy/val=%b%b addr=%h data=%h txns=%0d want 00 %h %h 0",
                  busy, mem_if.val, led_addr, led_data, txn_cnt - c, ref_addr, ref_led);
      end
      halted = 1'b1;
   endtask

   task automatic test_reset_abort();
      do_set(8'h70);
      mem_if.rdy = 1'b0;
      press(3'b001);
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({mem_if.val, mem_if.wen, busy, led_addr, led_data} !== 27'd0) begin
         n_bad++;
         $display("FAIL abort_state: val/wen/busy=%b%b%b addr=%h data=%h want 000 00 0000",
                  mem_if.val, mem_if.wen, busy, led_addr, led_data);
      end
      rst = 1'b0;
      mem_if.rdy = 1'b1;
      tick();
      press(3'b001);
      wait_idle(10, 1'b0);
      ref_addr = 8'h01;
      ref_led  = ref_mem[0];
      n_cmp++;
      if ({led_addr, led_data} !== {ref_addr, ref_led}) begin
         n_bad++;
         $display("FAIL abort_look: addr=%h data=%h want %h %h", led_addr, led_data, ref_addr, ref_led);
      end
   endtask

   task automatic test_random();
      int          op;
      logic [15:0] d;
      logic [7:0]  a;
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 2);
         mem_if.rdy = ($urandom_range(0, 1) != 0);
         if (op == 0) begin
            a = 8'($urandom);
            do_set(a);
            ref_addr = a;
         end else if (op == 1) begin
            d = 16'($urandom);
            sw_data = d;
            press(3'b010);
            wait_idle(60, 1'b1);
            ref_mem[ref_addr] = d;
            ref_led  = d;
            ref_addr = ref_addr + 8'd1;
         end else begin
            press(3'b001);
            wait_idle(60, 1'b1);
            ref_led  = ref_mem[ref_addr];
            ref_addr = ref_addr + 8'd1;
         end
         n_cmp++;
         if ({led_addr, led_data} !== {ref_addr, ref_led}) begin
            n_bad++;
            $display("FAIL random[%0d] op=%0d: addr=%h data=%h want %h %h",
                     i, op, led_addr, led_data, ref_addr, ref_led);
         end
      end
      mem_if.rdy = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      mem_if.rdy = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_wrap();
      test_simultaneous();
      test_busy_look();
      test_not_halted();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule
`default_nettype wire
